nx_stream_arbiter: RTL

Four-way message stream arbiter feeding one outbound stream through a single registered output slot. It generalises the two-input combining function of the mesh node to N requesters, such as inbound mesh ports plus a local node output. It supports round-robin or fixed-priority arbitration, with an anti-starvation override in fixed-priority mode. The source index of every forwarded message is reported alongside it.

---
 rtl/nx_constants_pkg.sv | 28 ++
 rtl/nx_rr_picker.sv | 40 ++++
 rtl/nx_stream_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/nx_constants_pkg.sv
`default_nettype none
// =============================================================================
// Module   : nx_constants_pkg
// Brief    : Shared mesh-node types and arbitration scheme constants.
// Revision : 1.0 - initial release
// =============================================================================
package nx_constants_pkg;

    localparam int unsigned NX_MSG_W = 32;
    localparam int unsigned NX_DIR_W = 3;

    typedef logic [NX_MSG_W-1:0] nx_message_t;
    typedef logic [NX_DIR_W-1:0] nx_direction_t;

    // Scheme names are carried as fixed-width character vectors so they can be
    // compared at elaboration time by both the combiner and the arbiter.
    localparam int unsigned NX_ARB_SCHEME_W = 8 * 12;
    typedef logic [NX_ARB_SCHEME_W-1:0] nx_arb_scheme_t;

    localparam nx_arb_scheme_t NX_ARB_ROUND_ROBIN = NX_ARB_SCHEME_W'("round_robin");
    localparam nx_arb_scheme_t NX_ARB_PRIORITY    = NX_ARB_SCHEME_W'("priority");

    function automatic logic nx_arb_is_priority(input nx_arb_scheme_t scheme);
        return (scheme == NX_ARB_PRIORITY);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nx_rr_picker.sv
`default_nettype none
// =============================================================================
// Module   : nx_rr_picker
// Brief    : Combinational rotating picker: first request at or after ptr_i.
// Revision : 1.0 - initial release
// =============================================================================
module nx_rr_picker #(
    parameter int unsigned N = 4,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] idx_o
);

    logic         w_found;
    logic [W:0]   w_pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < int'(N); k++) begin
            // Modulo-N wrap without a divider: N need not be a power of two.
            w_pos = {1'b0, ptr_i} + (W+1)'(k);
            if (w_pos >= (W+1)'(N)) begin
                w_pos = w_pos - (W+1)'(N);
            end
            if (!w_found && req_i[w_pos[W-1:0]]) begin
                w_found                 = 1'b1;
                grant_o[w_pos[W-1:0]]   = 1'b1;
                idx_o                   = w_pos[W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/nx_stream_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : nx_stream_arbiter
// Brief    : N-way message stream arbiter with a single registered output slot.
// Revision : 1.0 - initial release
// =============================================================================
module nx_stream_arbiter
    import nx_constants_pkg::*;
#(
    parameter int unsigned    INPUTS       = 4,
    parameter nx_arb_scheme_t ARB_SCHEME   = NX_ARB_ROUND_ROBIN,
    parameter int unsigned    STARVE_LIMIT = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  nx_message_t   [INPUTS-1:0]   in_data_i,
    input  nx_direction_t [INPUTS-1:0]   in_dir_i,
    input  logic          [INPUTS-1:0]   in_valid_i,
    output logic          [INPUTS-1:0]   in_ready_o,
    output nx_message_t                  comb_data_o,
    output nx_direction_t                comb_dir_o,
    output logic [$clog2(INPUTS)-1:0]    comb_src_o,
    output logic                         comb_valid_o,
    input  logic                         comb_ready_i
);

    localparam int unsigned SRC_W     = $clog2(INPUTS);
    localparam bit          c_is_prio = nx_arb_is_priority(ARB_SCHEME);

    logic [INPUTS-1:0] w_pick_req;
    logic [INPUTS-1:0] w_grant;
    logic [INPUTS-1:0] w_ready;
    logic [INPUTS-1:0] w_xfer_vec;
    logic [SRC_W-1:0]  w_pick_ptr;
    logic [SRC_W-1:0]  w_idx;
    logic              w_slot_free;
    logic              w_xfer;

    logic              r_valid;
    nx_message_t       r_data;
    nx_direction_t     r_dir;
    logic [SRC_W-1:0]  r_src;

    nx_rr_picker #(
        .N       (INPUTS)
    ) u_picker (
        .req_i   (w_pick_req),
        .ptr_i   (w_pick_ptr),
        .grant_o (w_grant),
        .idx_o   (w_idx)
    );

    // Reset gates ready so nothing is accepted on an edge that samples reset.
    assign w_slot_free = !r_valid || comb_ready_i;
    assign w_ready     = w_grant & {INPUTS{w_slot_free && !rst_i}};
    assign w_xfer_vec  = in_valid_i & w_ready;
    assign w_xfer      = |w_xfer_vec;

    generate
        if (c_is_prio) begin : g_prio
            localparam logic [7:0] c_limit = 8'(STARVE_LIMIT);
            logic [INPUTS-1:0] w_starved;

            for (genvar i = 0; i < int'(INPUTS); i++) begin : g_wait
                logic [7:0] r_wait;

                always_ff @(posedge clk_i or posedge rst_i) begin
                    if (rst_i) begin
                        r_wait <= '0;
                    end else if (!in_valid_i[i] || w_xfer_vec[i]) begin
                        r_wait <= '0;
                    end else if (r_wait != c_limit) begin
                        r_wait <= r_wait + 8'd1;
                    end
                end

                assign w_starved[i] = in_valid_i[i] && (r_wait == c_limit);
            end

            // Starved inputs pre-empt plain priority; lowest index still wins.
            assign w_pick_req = (|w_starved) ? w_starved : in_valid_i;
            assign w_pick_ptr = '0;
        end else begin : g_rr
            logic [SRC_W-1:0] r_ptr;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_ptr <= '0;
                end else if (w_xfer) begin
                    r_ptr <= (w_idx == SRC_W'(INPUTS - 1)) ? '0 : w_idx + SRC_W'(1);
                end
            end

            assign w_pick_req = in_valid_i;
            assign w_pick_ptr = r_ptr;
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_dir   <= '0;
            r_src   <= '0;
        end else if (w_slot_free) begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_data <= in_data_i[w_idx];
                r_dir  <= in_dir_i[w_idx];
                r_src  <= w_idx;
            end
        end
    end

    assign in_ready_o   = w_ready;
    assign comb_data_o  = r_data;
    assign comb_dir_o   = r_dir;
    assign comb_src_o   = r_src;
    assign comb_valid_o = r_valid;

endmodule
`default_nettype wire
